// File: rtl/truth_table_scanner_if.sv
// Bundles the scan control, result and gate-under-test signals of truth_table_scanner.
// The master side drives start/expected and the gate output; the slave side is the scanner.
interface truth_table_scanner_if #(
  parameter int N_IN = 2
);
  localparam int T = 2 ** N_IN;

  logic            start;
  logic [T-1:0]    expected;
  logic            dut_out;
  logic [N_IN-1:0] dut_in;
  logic            busy;
  logic            done;
  logic [T-1:0]    table_out;
  logic            match;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_err;

  modport master (
    output start, expected, dut_out,
    input  dut_in, busy, done, table_out, match, err_count, first_err
  );

  modport slave (
    input  start, expected, dut_out,
    output dut_in, busy, done, table_out, match, err_count, first_err
  );
endinterface

// File: rtl/truth_table_scanner.sv
// Sweeps every minterm onto a gate under test, samples its output after a settle delay
// and compares the measured truth table against an expected word.
//
// state  | meaning
// IDLE   | waiting for start, results held
// SETTLE | minterm applied, settle counter running
// SAMPLE | capture dut_out and compare at the closing edge
// DONE   | one-cycle done pulse, results valid
module truth_table_scanner #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_scanner_if.slave bus
);
  localparam int T  = 2 ** N_IN;
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_LAST  = CW'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [N_IN-1:0] r_minterm;
  logic [T-1:0]    r_exp;
  logic [T-1:0]    r_table;
  logic [N_IN:0]   r_err;
  logic [N_IN-1:0] r_first;
  logic            r_busy;
  logic            r_done;
  logic            r_match;

  logic            w_miss;
  logic [N_IN:0]   w_err_next;

  assign w_miss     = (bus.dut_out != r_exp[r_minterm]);
  assign w_err_next = r_err + (N_IN+1)'(w_miss);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_minterm <= '0;
      r_exp     <= '0;
      r_table   <= '0;
      r_err     <= '0;
      r_first   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_match   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_exp     <= bus.expected;
            r_minterm <= '0;
            r_table   <= '0;
            r_err     <= '0;
            r_first   <= '0;
            r_cnt     <= SETTLE_LD;
            r_busy    <= 1'b1;
            r_state   <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == CNT_LAST) r_state <= S_SAMPLE;
          else                   r_cnt   <= r_cnt - CNT_LAST;
        end
        S_SAMPLE: begin
          r_table[r_minterm] <= bus.dut_out;
          r_err              <= w_err_next;
          // first_err records only the lowest failing minterm of the sweep
          if (w_miss && (r_err == '0)) r_first <= r_minterm;
          if (&r_minterm) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_match <= (w_err_next == '0);
            r_state <= S_DONE;
          end else begin
            r_minterm <= r_minterm + 1'b1;
            r_cnt     <= SETTLE_LD;
            r_state   <= S_SETTLE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.dut_in    = r_minterm;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.table_out = r_table;
  assign bus.match     = r_match;
  assign bus.err_count = r_err;
  assign bus.first_err = r_first;
endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner driving a NOR gate, with a result scoreboard.
module tb_truth_table_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  truth_table_scanner_if #(.N_IN(2)) bus1 ();
  truth_table_scanner_if #(.N_IN(2)) bus3 ();

  assign bus1.dut_out = ~bus1.dut_in[0] & ~bus1.dut_in[1];
  assign bus3.dut_out = ~bus3.dut_in[0] & ~bus3.dut_in[1];

  truth_table_scanner #(.N_IN(2), .SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  truth_table_scanner #(.N_IN(2), .SETTLE(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  typedef struct {
    logic [3:0] tbl;
    logic [2:0] err;
    logic [1:0] first;
    logic       mt;
    int         lat;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: NOR truth table, bit m = ~a & ~b for minterm m.
  function automatic exp_t model(input logic [3:0] e, input int settle);
    exp_t r;
    logic [3:0] diff;
    r.tbl = '0;
    for (int m = 0; m < 4; m++) r.tbl[m] = (m == 0);
    diff    = r.tbl ^ e;
    r.err   = '0;
    r.first = '0;
    for (int m = 3; m >= 0; m--) begin
      if (diff[m]) begin
        r.err   = r.err + 3'd1;
        r.first = 2'(m);
      end
    end
    r.mt  = (diff == 4'b0000);
    r.lat = 4 * (settle + 1);
    return r;
  endfunction

  task automatic scan(input int sel, input logic [3:0] e, input int mid_edge);
    int   t0;
    int   lat;
    bit   seen;
    exp_t x;
    lat  = 0;
    seen = 0;
    @(negedge clk);
    if (sel == 1) begin bus1.start = 1'b1; bus1.expected = e; end
    else          begin bus3.start = 1'b1; bus3.expected = e; end
    @(negedge clk);
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    t0 = cyc;
    chk("busy_after_accept", (sel == 1) ? bus1.busy : bus3.busy, 1);
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (k == mid_edge) begin
        bus1.start    = 1'b1;
        bus1.expected = ~e;
      end
      @(negedge clk);
      bus1.start = 1'b0;
      if (sel == 3 && k < 16) chk("dut_in_step", bus3.dut_in, k / 4);
      if (((sel == 1) ? bus1.done : bus3.done) === 1'b1) begin
        seen = 1;
        lat  = cyc - t0;
      end
    end
    chk("done_seen", seen, 1);
    if (seen && sb.size() > 0) begin
      x = sb.pop_front();
      chk("done_latency", lat, x.lat);
      chk("table_out", (sel == 1) ? bus1.table_out : bus3.table_out, x.tbl);
      chk("err_count", (sel == 1) ? bus1.err_count : bus3.err_count, x.err);
      chk("match",     (sel == 1) ? bus1.match     : bus3.match,     x.mt);
      chk("busy_in_done", (sel == 1) ? bus1.busy : bus3.busy, 0);
      if (x.err != 0) chk("first_err", (sel == 1) ? bus1.first_err : bus3.first_err, x.first);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;
    bus1.start = 1'b0; bus1.expected = '0;
    bus3.start = 1'b0; bus3.expected = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dut_in",    bus1.dut_in, 0);
    chk("rst_busy",      bus1.busy, 0);
    chk("rst_done",      bus1.done, 0);
    chk("rst_table",     bus1.table_out, 0);
    chk("rst_match",     bus1.match, 0);
    chk("rst_err_count", bus1.err_count, 0);
    chk("rst_first_err", bus1.first_err, 0);
    rst_n = 1'b1;

    sb.push_back(model(4'b0001, 1));
    scan(1, 4'b0001, 0);
    @(negedge clk);
    chk("dut_in_hold", bus1.dut_in, 3);

    sb.push_back(model(4'b0111, 1));
    scan(1, 4'b0111, 0);

    sb.push_back(model(4'b1110, 1));
    scan(1, 4'b1110, 0);

    // Restart attempt and expected change at edge 3 must be ignored.
    sb.push_back(model(4'b0001, 1));
    scan(1, 4'b0001, 3);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus1.done === 1'b1) ndone++;
    end
    chk("no_extra_done", ndone, 0);
    chk("idle_after_ignored_start", bus1.busy, 0);

    // Reset mid-scan: outputs clear at once, no done pulse.
    @(negedge clk);
    bus1.start = 1'b1; bus1.expected = 4'b0001;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_dut_in", bus1.dut_in, 0);
    chk("midrst_busy",   bus1.busy, 0);
    chk("midrst_table",  bus1.table_out, 0);
    chk("midrst_match",  bus1.match, 0);
    chk("midrst_err",    bus1.err_count, 0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus1.done === 1'b1) ndone++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus1.done === 1'b1) ndone++;
    end
    chk("midrst_no_done", ndone, 0);

    sb.push_back(model(4'b0001, 1));
    scan(1, 4'b0001, 0);

    sb.push_back(model(4'b0001, 3));
    scan(3, 4'b0001, 0);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
